// File: rtl/key_input_debouncer_pkg.sv
// Shared types and 50 MHz default timing for the pushbutton debouncer.
package key_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_PEND = 2'd3
  } key_state_t;

  localparam int unsigned CLK_HZ                    = 50000000;
  // 20 ms of stable input before a level change is accepted.
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES   = 1000000;
  // 1 s of accepted press before the long-press pulse.
  localparam int unsigned DEFAULT_LONG_PRESS_CYCLES = 50000000;

endpackage

// File: rtl/key_debounce_chan.sv
// One key channel: 2-flop synchroniser, debounce FSM, hold counter and registered events.
// DEBOUNCE_CYCLES and LONG_PRESS_CYCLES must both be at least 2.
module key_debounce_chan
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_n,
  output logic       level_o,
  output logic       press_o,
  output logic       release_o,
  output logic       long_o,
  output logic [1:0] state_o
);

  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_PRESS_CYCLES - 1);

  logic              meta_q, meta_d;
  logic              sync_q, sync_d;
  key_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [HOLD_W-1:0] hold_inc;
  logic              hold_hit;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              long_q, long_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q    <= 1'b0;
      sync_q    <= 1'b0;
      state_q   <= RELEASED;
      cnt_q     <= '0;
      hold_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      meta_q    <= meta_d;
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  // Invert at the pin so everything downstream reads 1 = pressed.
  always_comb begin
    meta_d = ~key_n;
    sync_d = meta_q;
  end

  // Saturating hold increment; the long pulse fires only on the step into the threshold.
  always_comb begin
    hold_inc = (hold_q == HOLD_MAX) ? hold_q : hold_q + HOLD_ONE;
    hold_hit = (hold_q == HOLD_PRE);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;

    unique case (state_q)
      RELEASED: begin
        hold_d = '0;
        if (sync_q) begin
          state_d = PRESS_PEND;
          cnt_d   = CNT_ONE;
        end
      end

      PRESS_PEND: begin
        if (!sync_q) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          hold_d  = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      PRESSED: begin
        hold_d = hold_inc;
        long_d = hold_hit;
        if (!sync_q) begin
          state_d = RELEASE_PEND;
          cnt_d   = CNT_ONE;
        end
      end

      RELEASE_PEND: begin
        // An accepted release takes priority over a long press due on the same cycle.
        if (!sync_q && (cnt_q == CNT_LAST)) begin
          state_d   = RELEASED;
          cnt_d     = '0;
          hold_d    = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          hold_d = hold_inc;
          long_d = hold_hit;
          if (sync_q) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
        hold_d  = '0;
        level_d = 1'b0;
      end
    endcase
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;
  assign state_o   = state_q;

endmodule

// File: rtl/key_input_debouncer.sv
// Board pushbutton front end: N_KEYS independent debounced channels on CLOCK_50.
// KEY_STATE carries each channel's FSM state (2 bits per key) for observation.
module key_input_debouncer
  import key_pkg::*;
#(
  parameter int unsigned N_KEYS            = 4,
  parameter int unsigned DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET,
  input  logic [N_KEYS-1:0]     KEY,
  output logic [N_KEYS-1:0]     KEY_LEVEL,
  output logic [N_KEYS-1:0]     KEY_PRESS,
  output logic [N_KEYS-1:0]     KEY_RELEASE,
  output logic [N_KEYS-1:0]     KEY_LONG,
  output logic [2*N_KEYS-1:0]   KEY_STATE
);

  for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
    key_debounce_chan #(
      .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES)
    ) u_chan (
      .clk       (CLOCK_50),
      .rst       (RESET),
      .key_n     (KEY[g]),
      .level_o   (KEY_LEVEL[g]),
      .press_o   (KEY_PRESS[g]),
      .release_o (KEY_RELEASE[g]),
      .long_o    (KEY_LONG[g]),
      .state_o   (KEY_STATE[2*g +: 2])
    );
  end

endmodule
